rob: RTL and testbench

ROB -- requirements
Module: rob

---
 rtl/rob_pkg.sv | 10 +
 rtl/rob.sv | 122 ++++++++++++
 tb/tb_rob.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/rob_pkg.sv
// Payload type carried through the reorder buffer.
package rob_pkg;

    typedef struct packed {
        logic [4:0]  arch_reg;
        logic [5:0]  phys_reg;
        logic [15:0] pc;
    } ROB_EXIT_PACKET;

endpackage

// File: rtl/rob.sv
// Reorder buffer: circular queue of ROB_EXIT_PACKET entries.
// Dispatch writes up to N entries at the tail. Retire frees up to N entries at the head.
// A mispredict squash rewinds the tail to a checkpointed index.
// Ports:
//   clock, reset            system clock, synchronous active-low reset
//   rob_inputs/_valid       k new entries from dispatch, index 0 oldest
//   rob_spots               entries dispatch may write this cycle
//   rob_tail                current tail index, used for branch checkpoints
//   tail_restore(_valid)    squash request and the tail index to restore
//   rob_outputs/_valid      oldest N entries, index 0 at the head
//   num_retiring            head entries leaving this cycle
module rob
    import rob_pkg::*;
#(
    parameter int unsigned N               = 3,
    parameter int unsigned ROB_SZ          = 8,
    parameter int unsigned NUM_SCALAR_BITS = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  ROB_EXIT_PACKET [N-1:0]        rob_inputs,
    input  logic [NUM_SCALAR_BITS-1:0]    rob_inputs_valid,
    output logic [NUM_SCALAR_BITS-1:0]    rob_spots,
    output logic [$clog2(ROB_SZ)-1:0]     rob_tail,
    input  logic                          tail_restore_valid,
    input  logic [$clog2(ROB_SZ)-1:0]     tail_restore,
    output ROB_EXIT_PACKET [N-1:0]        rob_outputs,
    output logic [NUM_SCALAR_BITS-1:0]    rob_outputs_valid,
    input  logic [NUM_SCALAR_BITS-1:0]    num_retiring
);

    localparam int unsigned PTR_W  = $clog2(ROB_SZ);
    localparam int unsigned PTR_W1 = PTR_W + 1;
    localparam int unsigned CNT_W  = $clog2(ROB_SZ + 1);
    localparam logic [PTR_W:0] SZ_P = PTR_W1'(ROB_SZ);

    ROB_EXIT_PACKET       entries [ROB_SZ];
    logic [PTR_W-1:0]     head, tail, head_next, tail_next;
    logic [CNT_W-1:0]     count, count_next;
    logic [CNT_W-1:0]     free_slots;

    // (p + off) mod ROB_SZ; off never exceeds ROB_SZ so one subtraction suffices.
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input logic [PTR_W:0] off);
        logic [PTR_W:0] s;
        s = {1'b0, p} + off;
        if (s >= SZ_P) s = s - SZ_P;
        return s[PTR_W-1:0];
    endfunction

    // (a - b) mod ROB_SZ
    function automatic logic [PTR_W-1:0] ptr_dist(input logic [PTR_W-1:0] a, input logic [PTR_W-1:0] b);
        logic [PTR_W:0] d;
        if (a >= b) d = {1'b0, a} - {1'b0, b};
        else        d = {1'b0, a} + SZ_P - {1'b0, b};
        return d[PTR_W-1:0];
    endfunction

    // Status outputs depend on registered count only.
    always_comb begin
        free_slots = CNT_W'(ROB_SZ) - count;
        if (count < CNT_W'(N)) rob_outputs_valid = NUM_SCALAR_BITS'(count);
        else                   rob_outputs_valid = NUM_SCALAR_BITS'(N);
        if (free_slots < CNT_W'(N)) rob_spots = NUM_SCALAR_BITS'(free_slots);
        else                        rob_spots = NUM_SCALAR_BITS'(N);
        rob_tail = tail;
    end

    // Head window.
    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            rob_outputs[i] = entries[ptr_add(head, PTR_W1'(i))];
        end
    end

    // Next pointer/count. Squash replaces dispatch; retirement always applies.
    // A restore to the current tail squashes nothing, which also keeps a full ROB
    // from collapsing to empty when head == tail.
    always_comb begin
        head_next  = ptr_add(head, PTR_W1'(num_retiring));
        tail_next  = ptr_add(tail, PTR_W1'(rob_inputs_valid));
        count_next = count + CNT_W'(rob_inputs_valid) - CNT_W'(num_retiring);
        if (tail_restore_valid) begin
            tail_next = tail_restore;
            if (tail_restore == tail) count_next = count - CNT_W'(num_retiring);
            else                      count_next = CNT_W'(ptr_dist(tail_restore, head_next));
        end
    end

    // Pointer state.
    always_ff @(posedge clock) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head_next;
            tail  <= tail_next;
            count <= count_next;
        end
    end

    // Entry storage, not reset.
    always_ff @(posedge clock) begin
        if (reset && !tail_restore_valid) begin
            for (int unsigned j = 0; j < N; j++) begin
                if (NUM_SCALAR_BITS'(j) < rob_inputs_valid)
                    entries[ptr_add(tail, PTR_W1'(j))] <= rob_inputs[j];
            end
        end
    end

    // Illegal retire/dispatch counts.
    always_ff @(posedge clock) begin
        if (reset) begin
            assert (num_retiring <= rob_outputs_valid)
                else $error("rob: retire count exceeds occupied head entries");
            assert (tail_restore_valid || rob_inputs_valid <= rob_spots)
                else $error("rob: dispatch count exceeds free spots");
        end
    end

endmodule

// File: tb/tb_rob.sv
// Randomized and directed bench for rob (N=3, ROB_SZ=8) against a queue model.
module tb_rob;
    import rob_pkg::*;

    localparam int PW = $bits(ROB_EXIT_PACKET);

    logic                 clock = 1'b0;
    logic                 reset;
    ROB_EXIT_PACKET [2:0] rob_inputs;
    logic [1:0]           rob_inputs_valid;
    logic [1:0]           rob_spots;
    logic [2:0]           rob_tail;
    logic                 tail_restore_valid;
    logic [2:0]           tail_restore;
    ROB_EXIT_PACKET [2:0] rob_outputs;
    logic [1:0]           rob_outputs_valid;
    logic [1:0]           num_retiring;

    rob #(.N(3), .ROB_SZ(8), .NUM_SCALAR_BITS(2)) dut (
        .clock              (clock),
        .reset              (reset),
        .rob_inputs         (rob_inputs),
        .rob_inputs_valid   (rob_inputs_valid),
        .rob_spots          (rob_spots),
        .rob_tail           (rob_tail),
        .tail_restore_valid (tail_restore_valid),
        .tail_restore       (tail_restore),
        .rob_outputs        (rob_outputs),
        .rob_outputs_valid  (rob_outputs_valid),
        .num_retiring       (num_retiring)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    bit primed  = 1'b0;

    // Model: program-ordered queue of live entries plus the architectural head/tail indices.
    ROB_EXIT_PACKET mq[$];
    int m_head = 0;
    int m_tail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic ROB_EXIT_PACKET rand_pkt();
        logic [PW-1:0] b;
        b = PW'($urandom);
        return b;
    endfunction

    task automatic check_state();
        int sz;
        sz = mq.size();
        check("valid", 32'(rob_outputs_valid), 32'(imin(sz, 3)));
        check("spots", 32'(rob_spots), 32'(imin(3, 8 - sz)));
        check("tail", 32'(rob_tail), 32'(m_tail));
        for (int i = 0; i < imin(sz, 3); i++)
            check($sformatf("out%0d", i), 32'(rob_outputs[i]), 32'(mq[i]));
    endtask

    // One cycle: drive, check spots is unaffected by this cycle's retirement, clock, update model, check.
    task automatic step(input bit rst, input int k, input int r, input bit sq, input int tr);
        ROB_EXIT_PACKET p [3];
        int hn;
        int keep;
        for (int i = 0; i < 3; i++) begin
            p[i] = rand_pkt();
            rob_inputs[i] = p[i];
        end
        reset              = ~rst;
        rob_inputs_valid   = 2'(k);
        num_retiring       = 2'(r);
        tail_restore_valid = sq;
        tail_restore       = 3'(tr);
        #1;
        if (primed) check("spots_pre", 32'(rob_spots), 32'(imin(3, 8 - mq.size())));
        @(posedge clock);
        if (rst) begin
            mq.delete();
            m_head = 0;
            m_tail = 0;
        end else begin
            hn = (m_head + r) % 8;
            for (int i = 0; i < r; i++) void'(mq.pop_front());
            if (sq) begin
                if (tr != m_tail) begin
                    keep = (tr - hn + 8) % 8;
                    while (mq.size() > keep) void'(mq.pop_back());
                end
                m_tail = tr;
            end else begin
                for (int i = 0; i < k; i++) mq.push_back(p[i]);
                m_tail = (m_tail + k) % 8;
            end
            m_head = hn;
        end
        primed = 1'b1;
        #1;
        check_state();
    endtask

    initial begin
        int cnt, k, r, s, tr;
        bit sq;

        // Reset overrides a simultaneous dispatch.
        step(1, 3, 0, 0, 0);
        // A,B,C dispatched.
        step(0, 3, 0, 0, 0);
        check("abc_tail", 32'(rob_tail), 32'd3);
        // Fill to full, then hold.
        step(0, 3, 0, 0, 0);
        step(0, 2, 0, 0, 0);
        check("full_spots", 32'(rob_spots), 32'd0);
        step(0, 0, 0, 0, 0);
        // Retire 3 on full: spots stays 0 during the cycle, becomes 3 after.
        step(0, 0, 3, 0, 0);
        check("retire_spots", 32'(rob_spots), 32'd3);
        // head=6, count=2, tail=0; then wrapping dispatch with retire.
        step(0, 0, 3, 0, 0);
        step(0, 3, 2, 0, 0);
        check("wrap_tail", 32'(rob_tail), 32'd3);
        // Build head=2, tail=7, count=5; squash to 4 with r=1, k=2.
        step(0, 3, 2, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 2, 1, 1, 4);
        check("squash_valid", 32'(rob_outputs_valid), 32'd1);
        check("squash_tail", 32'(rob_tail), 32'd4);
        // Refill to full (tail=3), no-op squash to tail, then squash to head_next.
        step(0, 3, 0, 0, 0);
        step(0, 3, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 2, 0, 1, 3);
        check("noop_spots", 32'(rob_spots), 32'd0);
        step(0, 0, 1, 1, 4);
        check("empty_valid", 32'(rob_outputs_valid), 32'd0);

        // Randomized legal traffic.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(99, 0) < 2) begin
                step(1, int'($urandom_range(3, 0)), 0, 0, 0);
            end else begin
                cnt = mq.size();
                k   = int'($urandom_range(imin(3, 8 - cnt), 0));
                r   = int'($urandom_range(imin(cnt, 3), 0));
                sq  = ($urandom_range(5, 0) == 0);
                tr  = 0;
                if (sq) begin
                    s  = int'($urandom_range(cnt - r, 0));
                    tr = (m_head + r + s) % 8;
                end
                step(0, k, r, sq, tr);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
